// File: rtl/mem_copy_engine_pkg.sv
// Shared definitions for the block-copy initiator: FSM state encoding and
// default widths matching the 16x64k two-port memory.
package mem_copy_engine_pkg;

    localparam int MCE_ADDR_W = 16;
    localparam int MCE_DATA_W = 16;
    localparam int MCE_LEN_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

endpackage

// File: rtl/mem_copy_engine.sv
// Block copy through a two-port memory: port 1 reads, port 2 writes, one word/cycle.
// Latency: Done exactly Length+2 cycles after Start (1 cycle when Length==0).
// No backpressure: Start is honoured only in IDLE and is dropped otherwise. Optional MEM_COPY_CHECKSUM_EN.
module mem_copy_engine
    import mem_copy_engine_pkg::*;
#(
    parameter int ADDR_W = MCE_ADDR_W,
    parameter int DATA_W = MCE_DATA_W,
    parameter int LEN_W  = MCE_LEN_W
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Start,
    input  logic [ADDR_W-1:0] SrcAddr,
    input  logic [ADDR_W-1:0] DstAddr,
    input  logic [LEN_W-1:0]  Length,
    output logic              Busy,
    output logic              Done,
    output logic [DATA_W-1:0] Checksum,
    output logic [ADDR_W-1:0] Address_1,
    output logic              ReadEna_1,
    output logic              WriteEna_1,
    input  logic [DATA_W-1:0] DataOut_1,
    output logic [ADDR_W-1:0] Address_2,
    output logic              WriteEna_2,
    output logic              ReadEna_2,
    output logic [DATA_W-1:0] DataIn_2
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    // Set once the first read has been issued, i.e. read data is in flight.
    logic              wr_pend_q, wr_pend_d;
    logic              accept;

    assign accept = (state_q == ST_IDLE) && Start;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            rem_q     <= '0;
            wr_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            rem_q     <= rem_d;
            wr_pend_q <= wr_pend_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        rem_d     = rem_q;
        wr_pend_d = wr_pend_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    if (Length != '0) begin
                        state_d   = ST_RUN;
                        rd_ptr_d  = SrcAddr;
                        wr_ptr_d  = DstAddr;
                        rem_d     = Length;
                        wr_pend_d = 1'b0;
                    end else begin
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_RUN: begin
                rd_ptr_d  = rd_ptr_q + 1'b1;
                rem_d     = rem_q - 1'b1;
                wr_pend_d = 1'b1;
                if (wr_pend_q) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end
                if (rem_q == LEN_W'(1)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN:  state_d = ST_FINISH;
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs decode from state so the cycle after a reset is quiet.
    always_comb begin
        ReadEna_1  = (state_q == ST_RUN);
        WriteEna_2 = ((state_q == ST_RUN) && wr_pend_q) || (state_q == ST_DRAIN);
        Address_1  = ReadEna_1  ? rd_ptr_q  : '0;
        Address_2  = WriteEna_2 ? wr_ptr_q  : '0;
        DataIn_2   = WriteEna_2 ? DataOut_1 : '0;
        Busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        Done       = (state_q == ST_FINISH);
        WriteEna_1 = 1'b0;
        ReadEna_2  = 1'b0;
    end

`ifdef MEM_COPY_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            csum_q <= '0;
        end else if (accept) begin
            csum_q <= '0;
        end else if (WriteEna_2) begin
            csum_q <= csum_q + DataIn_2;
        end
    end

    assign Checksum = csum_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
    assign Checksum      = '0;
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// Randomized and directed copies against a transaction-level model of the copy engine.
module tb_mem_copy_engine;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [15:0] SrcAddr = '0, DstAddr = '0, Length = '0;
    logic        Busy, Done, ReadEna_1, WriteEna_1, WriteEna_2, ReadEna_2;
    logic [15:0] Checksum, Address_1, Address_2, DataIn_2, DataOut_1;

    mem_copy_engine dut (
        .CLK(CLK), .Reset(Reset), .Start(Start),
        .SrcAddr(SrcAddr), .DstAddr(DstAddr), .Length(Length),
        .Busy(Busy), .Done(Done), .Checksum(Checksum),
        .Address_1(Address_1), .ReadEna_1(ReadEna_1), .WriteEna_1(WriteEna_1),
        .DataOut_1(DataOut_1),
        .Address_2(Address_2), .WriteEna_2(WriteEna_2), .ReadEna_2(ReadEna_2),
        .DataIn_2(DataIn_2)
    );

    always #5 CLK = ~CLK;

    // Memory: registered read, read-before-write in the same cycle.
    logic [15:0] mem [int];
    logic [15:0] ref_mem [int];
    logic [15:0] rd_q = '0;
    logic        ld_we = 1'b0;
    logic [15:0] ld_addr = '0, ld_dat = '0;
    assign DataOut_1 = rd_q;

    function automatic logic [15:0] mget(input int a);
        return mem.exists(a) ? mem[a] : 16'h0;
    endfunction
    function automatic logic [15:0] rget(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : 16'h0;
    endfunction

    always @(posedge CLK) begin
        if (ReadEna_1) rd_q <= mget(int'(Address_1));
        if (WriteEna_2) mem[int'(Address_2)] = DataIn_2;
        if (ld_we) mem[int'(ld_addr)] = ld_dat;
    end

    int total = 0, bad = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model state
    bit          chk_en = 0, m_active = 0;
    int          m_c, m_len, obs_done_c, obs_busy_n, obs_en_n;
    logic [15:0] m_src, m_dst, exp_csum = '0;
    logic [15:0] m_snap [$];

    logic        e_rd, e_wr, e_busy, e_done;
    logic [15:0] e_a1, e_a2, e_d2, s;
    int          nw;

    always @(negedge CLK) begin
        if (chk_en) begin
            if (m_active) begin
                e_rd   = (m_c >= 1) && (m_c <= m_len);
                e_wr   = (m_c >= 2) && (m_c <= m_len + 1);
                e_a1   = e_rd ? 16'(m_src + 16'(m_c - 1)) : 16'h0;
                e_a2   = e_wr ? 16'(m_dst + 16'(m_c - 2)) : 16'h0;
                e_d2   = e_wr ? m_snap[m_c - 2] : 16'h0;
                e_busy = (m_len > 0) && (m_c >= 1) && (m_c <= m_len + 1);
                e_done = (m_len == 0) ? (m_c == 1) : (m_c == m_len + 2);
                if (e_done) begin
                    s = '0;
                    foreach (m_snap[i]) s = s + m_snap[i];
`ifdef MEM_COPY_CHECKSUM_EN
                    exp_csum = s;
`endif
                end
            end else begin
                {e_rd, e_wr, e_busy, e_done} = '0;
                {e_a1, e_a2, e_d2} = '0;
            end
            chk("ReadEna_1", ReadEna_1, e_rd);
            chk("WriteEna_2", WriteEna_2, e_wr);
            chk("Address_1", Address_1, e_a1);
            chk("Address_2", Address_2, e_a2);
            chk("DataIn_2", DataIn_2, e_d2);
            chk("Busy", Busy, e_busy);
            chk("Done", Done, e_done);
            chk("WriteEna_1", WriteEna_1, 0);
            chk("ReadEna_2", ReadEna_2, 0);
            if (!e_busy) chk("Checksum", Checksum, exp_csum);
            if (m_active) begin
                if (Done) obs_done_c = m_c;
                obs_busy_n += int'(Busy);
                obs_en_n   += int'(ReadEna_1 | WriteEna_2);
                if (Reset || e_done) begin
                    nw = e_done ? m_len : ((m_c - 1 < 0) ? 0 : ((m_c - 1 > m_len) ? m_len : m_c - 1));
                    for (int i = 0; i < nw; i++) ref_mem[int'(16'(m_dst + 16'(i)))] = m_snap[i];
                    m_active = 0;
                end else begin
                    m_c++;
                end
            end
            if (Reset) exp_csum = '0;
        end
    end

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        @(posedge CLK); #1;
        ld_we = 1'b1; ld_addr = a; ld_dat = d;
        ref_mem[int'(a)] = d;
        @(posedge CLK); #1;
        ld_we = 1'b0;
    endtask

    task automatic start_op(input logic [15:0] src, input logic [15:0] dst, input int len);
        @(posedge CLK); #1;
        Start = 1'b1; SrcAddr = src; DstAddr = dst; Length = 16'(len);
        m_src = src; m_dst = dst; m_len = len; m_c = 0;
        m_snap.delete();
        for (int i = 0; i < len; i++) m_snap.push_back(rget(int'(16'(src + 16'(i)))));
        obs_done_c = -1; obs_busy_n = 0; obs_en_n = 0;
        m_active = 1;
    endtask

    task automatic wait_op(input bit noise);
        int n = 0;
        while (m_active && n < 300) begin
            @(posedge CLK); #1;
            n++;
            if (noise && m_active) begin
                Start   = 1'($urandom_range(0, 1));
                SrcAddr = 16'($urandom); DstAddr = 16'($urandom);
                Length  = 16'($urandom_range(0, 40));
            end else begin
                Start = 1'b0;
            end
        end
        Start = 1'b0;
        chk("op_completes", {31'd0, m_active}, 0);
        m_active = 0;
    endtask

    task automatic mem_compare(input string nm);
        int diffs = 0;
        foreach (mem[k]) if (mem[k] !== rget(k)) diffs++;
        foreach (ref_mem[k]) if (ref_mem[k] !== mget(k)) diffs++;
        chk(nm, diffs, 0);
    endtask

    initial begin
        logic [15:0] src, dst, d;
        int len;

        @(posedge CLK); #1;
        chk_en = 1;
        repeat (2) @(posedge CLK);
        #1 Reset = 1'b0;

        // Basic 4-word copy
        preload(16'h0100, 16'h00A1); preload(16'h0101, 16'h00B2);
        preload(16'h0102, 16'h00C3); preload(16'h0103, 16'h00D4);
        start_op(16'h0100, 16'h0200, 4);
        wait_op(1'b0);
        chk("basic_done_lat", obs_done_c, 6);
        chk("basic_busy_n", obs_busy_n, 5);
        chk("basic_w0", mget(16'h0200), 16'h00A1);
        chk("basic_w1", mget(16'h0201), 16'h00B2);
        chk("basic_w2", mget(16'h0202), 16'h00C3);
        chk("basic_w3", mget(16'h0203), 16'h00D4);
        mem_compare("mem_basic");

        // Zero length
        start_op(16'h0100, 16'h0300, 0);
        wait_op(1'b0);
        chk("len0_done_lat", obs_done_c, 1);
        chk("len0_no_access", obs_en_n, 0);
        chk("len0_busy_n", obs_busy_n, 0);
        mem_compare("mem_len0");

        // Source wrap
        preload(16'hFFFE, 16'd1); preload(16'hFFFF, 16'd2);
        preload(16'h0000, 16'd3); preload(16'h0001, 16'd4);
        start_op(16'hFFFE, 16'h0010, 4);
        wait_op(1'b0);
        chk("wrap_w0", mget(16'h0010), 16'd1);
        chk("wrap_w1", mget(16'h0011), 16'd2);
        chk("wrap_w2", mget(16'h0012), 16'd3);
        chk("wrap_w3", mget(16'h0013), 16'd4);

        // Dst = Src+1
        preload(16'h0500, 16'd7); preload(16'h0501, 16'd8); preload(16'h0502, 16'd9);
        start_op(16'h0500, 16'h0501, 3);
        wait_op(1'b0);
        chk("shift_w0", mget(16'h0501), 16'd7);
        chk("shift_w1", mget(16'h0502), 16'd8);
        chk("shift_w2", mget(16'h0503), 16'd9);

        // Checksum wraps mod 2^16
        preload(16'h3000, 16'hFFFF); preload(16'h3001, 16'h0002);
        start_op(16'h3000, 16'h3100, 2);
        wait_op(1'b0);
`ifdef MEM_COPY_CHECKSUM_EN
        chk("csum_literal", Checksum, 16'h0001);
`else
        chk("csum_literal", Checksum, 16'h0000);
`endif

        // Second Start mid-copy is ignored; reset at cycle 5 aborts
        for (int i = 0; i < 8; i++) begin
            preload(16'(16'h0700 + i), 16'(16'h0011 + i));
            preload(16'(16'h0800 + i), 16'hEEEE);
        end
        start_op(16'h0700, 16'h0800, 8);
        for (int c = 1; c <= 6; c++) begin
            @(posedge CLK); #1;
            Start = (c == 2);
            if (c == 2) begin SrcAddr = 16'h0900; DstAddr = 16'h0A00; Length = 16'd3; end
            Reset = (c == 5);
        end
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_no_done", obs_done_c, -1);
        chk("rst_model_idle", {31'd0, m_active}, 0);
        for (int i = 0; i < 4; i++) chk("rst_written", mget(16'h0800 + 16'(i)), 16'(16'h0011 + i));
        for (int i = 4; i < 8; i++) chk("rst_untouched", mget(16'h0800 + 16'(i)), 16'hEEEE);
        mem_compare("mem_reset");

        // Randomized copies with Start noise while busy
        for (int t = 0; t < 30; t++) begin
            len = $urandom_range(0, 24);
            src = 16'($urandom);
            dst = 16'($urandom);
            if (t % 5 == 0) dst = 16'(src + 16'd1);
            d = 16'(dst - src);
            if (len >= 3 && d >= 16'd2 && d <= 16'(len - 1)) dst = src;
            for (int i = 0; i < len; i++) preload(16'(src + 16'(i)), 16'($urandom));
            start_op(src, dst, len);
            wait_op(1'b1);
        end
        mem_compare("mem_random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
- Initiator for the team's 16x64k two-port memory: copies a block of words from source to destination through the memory's two ports.
- Port 1 is used read-only; port 2 is used write-only.
- Sits between the control unit (or a debug loader) and the memory.
- Sustains 1 word/cycle using the memory's 1-cycle registered read latency.

Parameters:
- ADDR_W, 16, memory address width (matches memory ADDR_SIZE).
- DATA_W, 16, memory word width (matches memory MEM_WIDTH).
- LEN_W, 16, width of the Length field; maximum copy is 2^LEN_W-1 words.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  request pulse; sampled only in IDLE.
- SrcAddr  in  ADDR_W  first source word address.
- DstAddr  in  ADDR_W  first destination word address.
- Length  in  LEN_W  number of words to copy.
- Busy  out  1  high while a copy is in progress.
- Done  out  1  one-cycle completion pulse.
- Checksum  out  DATA_W  running sum of copied words (see Optional Feature).
- Address_1  out  ADDR_W  memory port-1 address (read).
- ReadEna_1  out  1  memory port-1 read enable.
- WriteEna_1  out  1  tied 0.
- DataOut_1  in  DATA_W  memory port-1 read data, valid the cycle after ReadEna_1.
- Address_2  out  ADDR_W  memory port-2 address (write).
- WriteEna_2  out  1  memory port-2 write enable.
- ReadEna_2  out  1  tied 0.
- DataIn_2  out  DATA_W  memory port-2 write data.

Behaviour:
- Reset:
  - State goes to IDLE.
  - Busy, Done, ReadEna_1, WriteEna_2 = 0.
  - Address_1, Address_2, DataIn_2 = 0.
  - Checksum = 0.
- States: IDLE, RUN, DRAIN, FINISH. Encoding is defined in the shared package.
- IDLE:
  - Start=1 with Length!=0: latch SrcAddr, DstAddr and Length; go to RUN.
  - Start=1 with Length==0: go to FINISH with no memory access.
  - Start=0: stay in IDLE.
- RUN (cycle k = 1..L after acceptance):
  - ReadEna_1=1, Address_1=Src+k-1.
  - From k=2 on: WriteEna_2=1, Address_2=Dst+k-2, DataIn_2=DataOut_1.
  - After the read of word L, go to DRAIN.
- DRAIN (one cycle, L+1):
  - ReadEna_1=0.
  - WriteEna_2=1, Address_2=Dst+L-1, DataIn_2=DataOut_1.
  - Go to FINISH.
- FINISH (one cycle): Done=1, Busy=0; go to IDLE.
- Latency: for Length=L>0, Done asserts exactly L+2 cycles after the Start cycle. For L=0, Done asserts 1 cycle after Start.
- Busy:
  - L>0: high from the cycle after Start through the DRAIN cycle inclusive.
  - L=0: never high.
- Start is ignored in RUN, DRAIN and FINISH; it is not queued.
- Address arithmetic is modulo 2^ADDR_W. Source and destination ranges wrap from 0xFFFF to 0x0000 silently.
- WriteEna_1 and ReadEna_2 are constant 0.
- Overlap:
  - Result is defined for non-overlapping ranges and for Dst<=Src+1. Dst=Src+1 is correct because the read is issued in the same cycle as the write and sees the old data.
  - Src+1<Dst<Src+L gives undefined destination contents; this case is not checked.
- Reset mid-copy:
  - Next cycle is IDLE with all enables 0 and no Done pulse.
  - Words already written remain in memory.
- Input ports SrcAddr, DstAddr and Length may change freely once accepted.

Optional Feature:
- Macro: MEM_COPY_CHECKSUM_EN.
- Defined:
  - Checksum clears to 0 on Start acceptance.
  - Each cycle WriteEna_2=1, Checksum adds DataIn_2, mod 2^DATA_W.
  - Value is final and stable from the FINISH cycle until the next accepted Start.
- Undefined: Checksum is constant 0 and no adder is synthesized.

Decomposition:
- Shared package/include holds:
  - state encodings (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2, FINISH=2'd3);
  - default widths ADDR_W/DATA_W/LEN_W = 16, identical to the memory's definitions.
- No sub-module. Read pointer, write pointer and remaining count are three registers in one module.

Test Plan:
- Preload mem[0x0100..0x0103]=A1,B2,C3,D4; Start Src=0x0100 Dst=0x0200 Len=4 -> mem[0x0200..0x0203]=A1,B2,C3,D4; Done exactly 6 cycles after Start; Busy high 5 cycles.
- Len=0 -> Done 1 cycle after Start; ReadEna_1 and WriteEna_2 never high; memory unchanged.
- Src=0xFFFE Dst=0x0010 Len=4 with mem[FFFE,FFFF,0000,0001]=1,2,3,4 -> mem[0x0010..0x0013]=1,2,3,4 (source wrap).
- Start pulsed again mid-copy (Len=8), then Reset asserted at cycle 5 -> second Start ignored; after Reset, enables low next cycle, no Done; mem[Dst..Dst+3] written, Dst+4.. unchanged.
- Dst=Src+1, Len=3, mem[Src..Src+2]=7,8,9 -> mem[Src+1..Src+3]=7,8,9.
- With MEM_COPY_CHECKSUM_EN, copy 0xFFFF,0x0002 -> Checksum=0x0001 at FINISH. Without the macro -> Checksum=0 throughout.
